udp_tx_formatter: RTL
=====================

# udp_tx_formatter

Parametrised UDP header/payload formatter for the FPGA Ethernet transmit path. It sits between the payload source and the MAC byte stream. Per packet it takes runtime source/destination ports and payload length, emits the 8-byte UDP header, then serialises payload words of `WORD_BYTES` bytes MSB-first. It supports any payload length, including odd lengths and zero, with a partial final word, and has AXI-stream handshakes on both sides.

## Interface
Parameters:
- `WORD_BYTES`, default 2: payload word width in bytes. Legal values are 1, 2, 4, 8.
- `MAX_PAYLOAD`, default 1472: largest accepted payload length in bytes. Must be ≤ 65527.

Ports:
- `clk`  in  1: single clock.
- `rst`  in  1: synchronous, active-high reset.
- `start`  in  1: request one packet. Sampled only in IDLE.
- `src_port`  in  16: UDP source port. Latched on accepted `start`.
- `dst_port`  in  16: UDP destination port. Latched on accepted `start`.
- `payload_len`  in  16: payload bytes. Latched on accepted `start`.
- `busy`  out  1: high from the cycle after an accepted `start` until the cycle after the last byte handshake.
- `done`  out  1: one-cycle pulse after the last byte handshake.
- `len_err`  out  1: one-cycle pulse when `start` is rejected because `payload_len` > `MAX_PAYLOAD`.
- `s_axis_tdata`  in  8*WORD_BYTES: payload word. The first byte on the wire is `[8*WORD_BYTES-1 -: 8]`.
- `s_axis_tvalid`  in  1: payload word valid.
- `s_axis_tready`  out  1: formatter accepts the word this cycle.
- `m_axis_tdata`  out  8: byte to MAC.
- `m_axis_tvalid`  out  1: output byte valid.
- `m_axis_tready`  in  1: MAC accepts the byte.
- `m_axis_tlast`  out  1: final byte of the packet.

## Operation
- States: IDLE, HDR, PAYLOAD, DONE.
- **IDLE:**
  - `start` with `payload_len` ≤ `MAX_PAYLOAD`: latch the port and length inputs, set `bytes_left` = `payload_len`, go to HDR.
  - `start` with `payload_len` > `MAX_PAYLOAD`: pulse `len_err` next cycle, stay in IDLE.
- **HDR:** emits 8 bytes, indexed 0..7:
  - bytes 0-1: `src_port[15:8]`, `[7:0]`
  - bytes 2-3: `dst_port[15:8]`, `[7:0]`
  - bytes 4-5: `udp_len[15:8]`, `[7:0]`, where `udp_len` = 8 + `payload_len` (16-bit, no overflow given the `MAX_PAYLOAD` limit)
  - bytes 6-7: 0x00, 0x00 (checksum disabled)
  - On the handshake of byte 7: go to PAYLOAD, or to DONE if `payload_len` == 0. In the zero-length case byte 7 carries `m_axis_tlast`.
- **Word buffer:** a single word buffer plus byte index (0..WORD_BYTES-1).
  - `s_axis_tready` = (state is HDR or PAYLOAD) && `words_left` > 0 && (buffer empty || last needed byte of the buffer is handshaking this cycle).
  - `words_left` = ceil(`payload_len`/`WORD_BYTES`), decremented per accepted word.
  - The first word may therefore be prefetched during HDR.
- **PAYLOAD:**
  - Each output slot takes the next byte of the buffer, MSB first, and decrements `bytes_left`.
  - The byte with `bytes_left` == 1 carries `m_axis_tlast`.
  - For a partial final word, the unused low bytes are discarded.
  - If the buffer is empty, `m_axis_tvalid` deasserts (bubble) until a word arrives.
  - On the handshake of the last byte: go to DONE.
- **DONE:** one cycle. `done`=1, `busy`=0, return to IDLE. A `start` in DONE is ignored.
- A `start` while busy is ignored. The latched inputs are not affected by input changes mid-packet.

## Timing
- **Reset values:**
  - `busy`, `done`, `len_err`, `s_axis_tready`, `m_axis_tvalid`, `m_axis_tlast` = 0
  - `m_axis_tdata` = 0x00
  - state = IDLE; buffer and counters cleared.
- **Reset mid-packet:** outputs take their reset values on the next edge. The partial packet is abandoned with no `tlast`. Words already taken are lost.
- **Output register:** `m_axis_*` are registered. While `m_axis_tvalid`=1 and `m_axis_tready`=0, `tdata`, `tvalid` and `tlast` hold stable.
- **Latency:** `start` at cycle 0 gives header byte 0 valid at cycle 1.
- **Throughput:** with `m_axis_tready` and `s_axis_tvalid` held high, output is gapless, one byte per cycle.
  - Last byte at cycle 8+`payload_len`.
  - `done` at cycle 9+`payload_len`.
  - Next `start` accepted at cycle 10+`payload_len`.
- **Simultaneous events:** an output handshake on the buffer's last byte and an input word accept in the same cycle produce the next byte with no bubble.
- `s_axis_tready` is never asserted once `words_left` == 0. Extra upstream words are left unconsumed.

## Test plan
- **Basic packet:** WORD_BYTES=2, `src_port`=0xC350, `dst_port`=0xEA60, len=4, words 0x1122, 0x3344, tready=1.
  - Output bytes C3 50 EA 60 00 0C 00 00 11 22 33 44.
  - `tlast` on 0x44 only; `done` one cycle later; 12 output cycles.
- **Odd length:** WORD_BYTES=4, len=5, words 0xAABBCCDD, 0xEE112233.
  - Payload bytes AA BB CC DD EE, `tlast` on EE, length field 0x000D.
  - Exactly 2 words accepted.
- **Zero length:** len=0.
  - 8 header bytes, length field 0x0008, `tlast` on byte 7.
  - `s_axis_tready` never asserted.
- **Backpressure and bubbles:** random `m_axis_tready` and `s_axis_tvalid`, len=64, WORD_BYTES=2.
  - Data stable while stalled; byte order matches the source.
  - Exactly one `tlast`; 32 words accepted.
- **Rejected length:** `payload_len`=MAX_PAYLOAD+1.
  - `len_err` pulse, `busy` stays 0, no output.
  - Next `start` with len=2 is sent correctly.
- **Reset mid-packet:** assert `rst` during payload byte 3.
  - All outputs are 0 the next cycle.
  - A following packet is emitted cleanly from header byte 0.

Source files
------------

// File: rtl/udp_tx_formatter.sv
// udp_tx_formatter: prepends the 8-byte UDP header to a payload stream and
// serialises WORD_BYTES-wide payload words MSB-first onto a registered
// 8-bit AXI stream toward the MAC.
module udp_tx_formatter #(
   parameter int WORD_BYTES  = 2,
   parameter int MAX_PAYLOAD = 1472
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic [15:0]             src_port,
   input  logic [15:0]             dst_port,
   input  logic [15:0]             payload_len,
   output logic                    busy,
   output logic                    done,
   output logic                    len_err,
   input  logic [8*WORD_BYTES-1:0] s_axis_tdata,
   input  logic                    s_axis_tvalid,
   output logic                    s_axis_tready,
   output logic [7:0]              m_axis_tdata,
   output logic                    m_axis_tvalid,
   input  logic                    m_axis_tready,
   output logic                    m_axis_tlast
);
   localparam int DW = 8*WORD_BYTES;
   localparam int IW = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(WORD_BYTES-1);
   localparam logic [15:0]   MAX_LEN  = 16'(MAX_PAYLOAD);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_HDR  = 2'd1;
   localparam logic [1:0] S_PAY  = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   logic [1:0]    state_q, state_d;
   logic [15:0]   src_q, src_d, dst_q, dst_d, len_q, len_d;
   logic [15:0]   bleft_q, bleft_d;   // payload bytes not yet loaded into the output register
   logic [15:0]   wleft_q, wleft_d;   // payload words still to accept upstream
   logic [2:0]    hidx_q, hidx_d;     // header byte currently presented
   logic [DW-1:0] buf_q, buf_d;
   logic          bvld_q, bvld_d;
   logic [IW-1:0] bidx_q, bidx_d;
   logic [7:0]    tdata_q, tdata_d;
   logic          tvalid_q, tvalid_d, tlast_q, tlast_d;
   logic          done_q, done_d, lerr_q, lerr_d;

   logic          hs, out_adv, want_pay, take, take_last, s_rdy, s_acc;
   logic [DW-1:0] buf_sh;
   logic [7:0]    cur_byte;
   logic [15:0]   udp_len;

   function automatic logic [7:0] hdr_byte(input logic [2:0] i, input logic [15:0] s,
                                           input logic [15:0] d, input logic [15:0] l);
      case (i)
         3'd0:    hdr_byte = s[15:8];
         3'd1:    hdr_byte = s[7:0];
         3'd2:    hdr_byte = d[15:8];
         3'd3:    hdr_byte = d[7:0];
         3'd4:    hdr_byte = l[15:8];
         3'd5:    hdr_byte = l[7:0];
         default: hdr_byte = 8'h00;   // checksum disabled
      endcase
   endfunction

   // Next-state logic: packet FSM, output register loading and word buffer.
   always_comb begin
      hs        = tvalid_q & m_axis_tready;
      out_adv   = ~tvalid_q | m_axis_tready;
      // A payload byte is wanted whenever the output slot frees up in PAYLOAD,
      // or as header byte 7 leaves (first payload byte follows with no gap).
      want_pay  = ((state_q == S_PAY) && out_adv) ||
                  ((state_q == S_HDR) && hs && (hidx_q == 3'd7) && (len_q != 16'd0));
      take      = want_pay && bvld_q && (bleft_q != 16'd0);
      // Buffer frees on its final byte, or early when the packet ends mid-word.
      take_last = take && ((bidx_q == LAST_IDX) || (bleft_q == 16'd1));
      s_rdy     = ((state_q == S_HDR) || (state_q == S_PAY)) && (wleft_q != 16'd0) &&
                  (!bvld_q || take_last);
      s_acc     = s_rdy && s_axis_tvalid;
      buf_sh    = buf_q << {bidx_q, 3'b000};
      cur_byte  = buf_sh[DW-1 -: 8];
      udp_len   = len_q + 16'd8;

      state_d  = state_q;
      src_d    = src_q;
      dst_d    = dst_q;
      len_d    = len_q;
      bleft_d  = bleft_q;
      wleft_d  = wleft_q;
      hidx_d   = hidx_q;
      buf_d    = buf_q;
      bvld_d   = bvld_q;
      bidx_d   = bidx_q;
      tdata_d  = tdata_q;
      tvalid_d = tvalid_q;
      tlast_d  = tlast_q;
      done_d   = 1'b0;
      lerr_d   = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               if (payload_len > MAX_LEN) begin
                  lerr_d = 1'b1;
               end else begin
                  state_d  = S_HDR;
                  src_d    = src_port;
                  dst_d    = dst_port;
                  len_d    = payload_len;
                  bleft_d  = payload_len;
                  wleft_d  = 16'(({1'b0, payload_len} + 17'(WORD_BYTES-1)) / 17'(WORD_BYTES));
                  hidx_d   = 3'd0;
                  bvld_d   = 1'b0;
                  bidx_d   = '0;
                  tdata_d  = src_port[15:8];
                  tvalid_d = 1'b1;
                  tlast_d  = 1'b0;
               end
            end
         end
         S_HDR: begin
            if (hs) begin
               if (hidx_q == 3'd7) begin
                  if (len_q == 16'd0) begin
                     state_d  = S_DONE;
                     tvalid_d = 1'b0;
                     tlast_d  = 1'b0;
                     done_d   = 1'b1;
                  end else begin
                     state_d  = S_PAY;
                     tvalid_d = take;
                     tlast_d  = take && (bleft_q == 16'd1);
                     if (take) begin
                        tdata_d = cur_byte;
                        bleft_d = bleft_q - 16'd1;
                     end
                  end
               end else begin
                  hidx_d  = hidx_q + 3'd1;
                  tdata_d = hdr_byte(hidx_q + 3'd1, src_q, dst_q, udp_len);
                  tlast_d = (hidx_q == 3'd6) && (len_q == 16'd0);
               end
            end
         end
         S_PAY: begin
            if (hs && tlast_q) begin
               state_d  = S_DONE;
               tvalid_d = 1'b0;
               tlast_d  = 1'b0;
               done_d   = 1'b1;
            end else if (out_adv) begin
               tvalid_d = take;   // empty buffer gives a bubble
               tlast_d  = take && (bleft_q == 16'd1);
               if (take) begin
                  tdata_d = cur_byte;
                  bleft_d = bleft_q - 16'd1;
               end
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      if (take) begin
         if (take_last) begin
            bvld_d = 1'b0;
            bidx_d = '0;
         end else begin
            bidx_d = bidx_q + 1'b1;
         end
      end
      // A word accepted in the same cycle the old one drains refills the buffer.
      if (s_acc) begin
         buf_d   = s_axis_tdata;
         bvld_d  = 1'b1;
         bidx_d  = '0;
         wleft_d = wleft_q - 16'd1;
      end
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         src_q    <= '0;
         dst_q    <= '0;
         len_q    <= '0;
         bleft_q  <= '0;
         wleft_q  <= '0;
         hidx_q   <= '0;
         buf_q    <= '0;
         bvld_q   <= 1'b0;
         bidx_q   <= '0;
         tdata_q  <= '0;
         tvalid_q <= 1'b0;
         tlast_q  <= 1'b0;
         done_q   <= 1'b0;
         lerr_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         src_q    <= src_d;
         dst_q    <= dst_d;
         len_q    <= len_d;
         bleft_q  <= bleft_d;
         wleft_q  <= wleft_d;
         hidx_q   <= hidx_d;
         buf_q    <= buf_d;
         bvld_q   <= bvld_d;
         bidx_q   <= bidx_d;
         tdata_q  <= tdata_d;
         tvalid_q <= tvalid_d;
         tlast_q  <= tlast_d;
         done_q   <= done_d;
         lerr_q   <= lerr_d;
      end
   end

   assign busy          = (state_q == S_HDR) || (state_q == S_PAY);
   assign done          = done_q;
   assign len_err       = lerr_q;
   assign s_axis_tready = s_rdy;
   assign m_axis_tdata  = tdata_q;
   assign m_axis_tvalid = tvalid_q;
   assign m_axis_tlast  = tlast_q;

endmodule
